// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register plus req/ack instruction fetch presenting {inst, pc} to decode.
// Optional PC_ALIGN_CHECK_EN: misaligned npc sets sticky misalign and halts fetch until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      npc,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign
);
`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_VALID, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_VALID} state_t;
`endif
  state_t      state, state_nx;
  logic        take, accept, bad;
  logic [31:0] pc_nx;
  always_comb begin
    take     = state == S_REQ && imem_ack;
    accept   = state == S_VALID && inst_ready;
`ifdef PC_ALIGN_CHECK_EN
    bad      = accept && npc[1:0] != 2'b00;
    pc_nx    = npc;
    state_nx = take ? S_VALID : bad ? S_HALT : accept ? S_REQ : state;
`else
    bad      = 1'b0;
    pc_nx    = npc & 32'hFFFF_FFFC;
    state_nx = take ? S_VALID : accept ? S_REQ : state;
`endif
  end
  // req is gated by rst_n so it drops immediately when reset asserts
  assign imem_req   = rst_n && state == S_REQ;
  assign imem_addr  = pc;
  assign inst_valid = state == S_VALID;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nx;
      if (take) inst <= imem_rdata;
      if (accept) begin
        pc        <= pc_nx;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else if (bad) misalign <= 1'b1;
  end
`else
  assign misalign = bad;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model of the fetch unit.
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_3000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] npc = '0;
  logic [31:0] pc, imem_addr, inst;
  logic        imem_req, imem_ack = 1'b0, inst_valid, inst_ready = 1'b0, misalign;
  logic [31:0] imem_rdata = '0;
  logic [3:0]  fetch_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc = RPC, m_inst = '0;
  int          m_cnt = 0;
  bit          m_have = 0, m_halt = 0, m_mis = 0, chk_en = 0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1;
`else
  localparam bit ALIGN_EN = 0;
`endif

  pc_fetch_unit #(.RESET_PC(RPC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .pc(pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: an instruction is either being fetched, held for decode, or fetch is halted.
  function automatic void model_reset();
    m_pc = RPC; m_inst = '0; m_cnt = 0; m_have = 0; m_halt = 0; m_mis = 0;
  endfunction

  function automatic void model_clock();
    if (!rst_n) return;
    if (!m_have && !m_halt) begin
      if (imem_ack) begin m_inst = imem_rdata; m_have = 1; end
    end else if (m_have && inst_ready) begin
      m_cnt = (m_cnt + 1) % 16;
      m_have = 0;
      if (ALIGN_EN && npc % 4 != 0) begin m_pc = npc; m_mis = 1; m_halt = 1; end
      else m_pc = npc - npc % 4;
    end
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", 32'(imem_req), 32'(rst_n && !m_have && !m_halt));
    chk("inst_valid", 32'(inst_valid), 32'(m_have));
    chk("inst", inst, m_inst);
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    chk("misalign", 32'(misalign), 32'(m_mis));
  end

  // Called at negedge+2; drives inputs for the next rising edge.
  task automatic cycle(input logic a, input logic [31:0] d, input logic r, input logic [31:0] n);
    imem_ack = a; imem_rdata = d; inst_ready = r; npc = n;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input logic stray);
    rst_n = 1'b0;
    model_reset();
    imem_ack = stray; imem_rdata = 32'hBAD0_BAD0; inst_ready = stray;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", pc, RPC);
    chk("rst_cnt", 32'(fetch_cnt), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #2;
    chk_en = 1;
    do_reset(1'b0);
    // Test 1: ack one cycle after req
    cycle(0, 0, 0, 0);
    chk("t1_addr", imem_addr, 32'h3000);
    chk("t1_req", 32'(imem_req), 32'h1);
    cycle(1, 32'h2408_0005, 0, 0);
    chk("t1_valid", 32'(inst_valid), 32'h1);
    chk("t1_inst", inst, 32'h2408_0005);
    cycle(0, 0, 1, 32'h3004);
    chk("t1_pc", pc, 32'h3004);
    chk("t1_cnt", 32'(fetch_cnt), 32'h1);
    // Test 2: zero-wait ack, then a three-cycle wait
    cycle(1, 32'h1111_0001, 0, 0);
    chk("t2_zw_valid", 32'(inst_valid), 32'h1);
    cycle(0, 0, 1, 32'h3008);
    for (int i = 0; i < 3; i++) begin
      cycle(0, $urandom, 0, $urandom);
      chk("t2_wait_addr", imem_addr, 32'h3008);
    end
    cycle(1, 32'h2222_0002, 0, 0);
    chk("t2_w3_valid", 32'(inst_valid), 32'h1);
    // Test 3: decode stalls with npc moving
    for (int i = 0; i < 5; i++) cycle(0, $urandom, 0, $urandom);
    chk("t3_hold_pc", pc, 32'h3008);
    chk("t3_hold_inst", inst, 32'h2222_0002);
    cycle(0, 0, 1, 32'h3010);
    chk("t3_pc", pc, 32'h3010);
    // Test 4: reset while waiting for ack at 0x3008, with a stray ack
    cycle(1, 32'h3333_0003, 0, 0);
    cycle(0, 0, 1, 32'h3008);
    chk("t4_pre_pc", pc, 32'h3008);
    do_reset(1'b1);
    cycle(0, 0, 0, 0);
    chk("t4_pc", pc, RPC);
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_cnt", 32'(fetch_cnt), 32'h0);
    // Test 5: counter wraps after 16 accepts; ack outside fetch is ignored
    for (int i = 0; i < 16; i++) begin
      cycle(1, $urandom, 0, 0);
      cycle(0, 0, 1, m_pc + 32'd4);
    end
    chk("t5_wrap", 32'(fetch_cnt), 32'h0);
    cycle(1, 32'h5555_0005, 0, 0);
    cycle(1, 32'hDEAD_BEEF, 0, 0);
    chk("t5_stray_inst", inst, 32'h5555_0005);
    chk("t5_stray_valid", 32'(inst_valid), 32'h1);
    // Test 6: misaligned npc
    cycle(0, 0, 1, 32'h3006);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_mis", 32'(misalign), 32'h1);
    chk("t6_req", 32'(imem_req), 32'h0);
    cycle(1, 32'h6666_0006, 1, 0);
    chk("t6_halt_req", 32'(imem_req), 32'h0);
    do_reset(1'b0);
`else
    chk("t6_pc", pc, 32'h3004);
    chk("t6_req", 32'(imem_req), 32'h1);
    cycle(1, 32'h6666_0006, 0, 0);
    chk("t6_cont", 32'(inst_valid), 32'h1);
`endif
    // Random traffic with occasional misaligned npc and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 1) == 1);
      else cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
